// File: rtl/iob_eth_buf_arb.sv
// Round-robin arbiter that lets the Ethernet MAC Wishbone master and the CPU IOb
// port share one single-port packet-buffer RAM, one word per IDLE/ACCESS/RESP pass.
module iob_eth_buf_arb #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int WB_ADDR_W  = 32,
  parameter int MEM_ADDR_W = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WB_ADDR_W-1:0]  m_wb_adr_i,
  input  logic [DATA_W/8-1:0]   m_wb_sel_i,
  input  logic                  m_wb_we_i,
  input  logic [DATA_W-1:0]     m_wb_dat_i,
  input  logic                  m_wb_cyc_i,
  input  logic                  m_wb_stb_i,
  output logic [DATA_W-1:0]     m_wb_dat_o,
  output logic                  m_wb_ack_o,
  output logic                  m_wb_err_o,
  input  logic                  valid,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ready,
  output logic                  mem_en,
  output logic [DATA_W/8-1:0]   mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic                  r_lastMac;
  logic                  r_grantMac;
  logic                  r_err;
  logic                  r_we;
  logic [MEM_ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [STRB_W-1:0]     r_strb;
  logic [DATA_W-1:0]     r_macRdata;
  logic [DATA_W-1:0]     r_cpuRdata;

  logic w_ethReq;
  logic w_anyReq;
  logic w_pickMac;
  logic w_macOutOfRange;
  logic w_access;
  logic w_resp;
  logic w_unused;

  assign w_ethReq        = m_wb_cyc_i & m_wb_stb_i;
  assign w_anyReq        = w_ethReq | valid;
  // On contention the MAC wins only if the CPU was served last.
  assign w_pickMac       = w_ethReq & (~valid | ~r_lastMac);
  assign w_macOutOfRange = |m_wb_adr_i[WB_ADDR_W-1:MEM_ADDR_W+2];
  assign w_unused        = ^{address[ADDR_W-1:MEM_ADDR_W+2], address[1:0], m_wb_adr_i[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_anyReq) w_nextState = ACCESS;
      ACCESS:  w_nextState = RESP;
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lastMac  <= 1'b0;
      r_grantMac <= 1'b0;
      r_err      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_strb     <= '0;
    end else if (r_state == IDLE && w_anyReq) begin
      r_grantMac <= w_pickMac;
      r_lastMac  <= w_pickMac;
      if (w_pickMac) begin
        r_addr  <= m_wb_adr_i[MEM_ADDR_W+1:2];
        r_wdata <= m_wb_dat_i;
        r_strb  <= m_wb_sel_i;
        r_we    <= m_wb_we_i;
        r_err   <= w_macOutOfRange;
      end else begin
        r_addr  <= address[MEM_ADDR_W+1:2];
        r_wdata <= wdata;
        r_strb  <= wstrb;
        r_we    <= |wstrb;
        r_err   <= 1'b0;
      end
    end
  end

  // RAM data arrives during RESP; each requester keeps its last read value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_macRdata <= '0;
      r_cpuRdata <= '0;
    end else if (r_state == RESP && !r_we) begin
      if (r_grantMac && !r_err) begin
        r_macRdata <= mem_rdata;
      end else if (!r_grantMac) begin
        r_cpuRdata <= mem_rdata;
      end
    end
  end

  assign w_access   = (r_state == ACCESS) & ~r_err;
  assign w_resp     = (r_state == RESP);

  assign mem_en     = w_access;
  assign mem_we     = (w_access && r_we) ? r_strb : '0;
  assign mem_addr   = w_access ? r_addr : '0;
  assign mem_wdata  = w_access ? r_wdata : '0;
  assign busy       = (r_state == ACCESS) | w_resp;
  assign m_wb_ack_o = w_resp & r_grantMac & ~r_err;
  assign m_wb_err_o = w_resp & r_grantMac & r_err;
  assign ready      = w_resp & ~r_grantMac;
  assign m_wb_dat_o = r_macRdata;
  assign rdata      = r_cpuRdata;

endmodule

// File: tb/tb_iob_eth_buf_arb.sv
// Bench for iob_eth_buf_arb: table vectors, contention and reset-abort sequences,
// then random traffic checked against an array model of the buffer RAM.
module tb_iob_eth_buf_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] m_wb_adr_i = '0;
  logic [3:0]  m_wb_sel_i = '0;
  logic        m_wb_we_i = 1'b0;
  logic [31:0] m_wb_dat_i = '0;
  logic        m_wb_cyc_i = 1'b0;
  logic        m_wb_stb_i = 1'b0;
  logic [31:0] m_wb_dat_o;
  logic        m_wb_ack_o;
  logic        m_wb_err_o;
  logic        valid = 1'b0;
  logic [15:0] address = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        busy;

  iob_eth_buf_arb dut (
    .clk        (clk),
    .rst        (rst),
    .m_wb_adr_i (m_wb_adr_i),
    .m_wb_sel_i (m_wb_sel_i),
    .m_wb_we_i  (m_wb_we_i),
    .m_wb_dat_i (m_wb_dat_i),
    .m_wb_cyc_i (m_wb_cyc_i),
    .m_wb_stb_i (m_wb_stb_i),
    .m_wb_dat_o (m_wb_dat_o),
    .m_wb_ack_o (m_wb_ack_o),
    .m_wb_err_o (m_wb_err_o),
    .valid      (valid),
    .address    (address),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .rdata      (rdata),
    .ready      (ready),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Byte-writable synchronous RAM standing in for the packet buffer.
  logic [31:0] ram [0:2047];
  initial for (int i = 0; i < 2048; i++) ram[i] = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= ram[mem_addr];
    end
  end

  int total = 0;
  int bad = 0;

  logic [31:0] refMem [0:2047];
  logic [31:0] refMacRd;
  logic [31:0] refCpuRd;
  logic        mErr;
  logic        mWr;
  logic [10:0] mIdx;

  int          pulseK;
  logic [2:0]  kind;
  int          enCount;
  int          busyCount;
  logic [3:0]  weSeen;
  logic [10:0] addrSeen;

  typedef struct {
    logic        isMac;
    logic        isWrite;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        expErr;
    logic [31:0] expMac;
    logic [31:0] expCpu;
  } vec_t;
  vec_t vecs [14];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    refMacRd = '0;
    refCpuRd = '0;
  endtask

  task automatic modelStep(input logic isMac, input logic isWrite, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb);
    mIdx = addr[12:2];
    mErr = isMac && (addr[31:13] != 0);
    mWr  = isMac ? isWrite : (isWrite && strb != 0);
    if (!mErr) begin
      if (mWr) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) refMem[mIdx][8*b +: 8] = data[8*b +: 8];
      end else if (isMac) begin
        refMacRd = refMem[mIdx];
      end else begin
        refCpuRd = refMem[mIdx];
      end
    end
  endtask

  task automatic dropRequests();
    m_wb_cyc_i = 1'b0; m_wb_stb_i = 1'b0; m_wb_we_i = 1'b0;
    m_wb_sel_i = '0;   m_wb_adr_i = '0;   m_wb_dat_i = '0;
    valid = 1'b0; address = '0; wdata = '0; wstrb = '0;
  endtask

  // Drives one request and watches until its completion pulse (bounded).
  task automatic applyStimulus(input logic isMac, input logic isWrite, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb);
    @(posedge clk); #1;
    if (isMac) begin
      m_wb_cyc_i = 1'b1; m_wb_stb_i = 1'b1; m_wb_we_i = isWrite;
      m_wb_adr_i = addr; m_wb_dat_i = data; m_wb_sel_i = strb;
    end else begin
      valid = 1'b1; address = addr[15:0]; wdata = data;
      wstrb = isWrite ? strb : 4'h0;
    end
    pulseK = -1; kind = '0; enCount = 0; busyCount = 0; weSeen = '0; addrSeen = '0;
    for (int k = 0; k < 8 && pulseK < 0; k++) begin
      @(negedge clk);
      if (busy) busyCount++;
      if (mem_en) begin
        enCount++;
        weSeen = mem_we;
        addrSeen = mem_addr;
      end
      if (m_wb_ack_o || m_wb_err_o || ready) begin
        pulseK = k;
        kind = {m_wb_ack_o, m_wb_err_o, ready};
      end
    end
    @(posedge clk); #1;
    dropRequests();
    @(negedge clk);
  endtask

  task automatic exercise(input logic isMac, input logic isWrite, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb, input logic useTable,
                          input logic tErr, input logic [31:0] tMac, input logic [31:0] tCpu);
    logic        expErr;
    logic [31:0] expMac;
    logic [31:0] expCpu;
    modelStep(isMac, isWrite, addr, data, strb);
    applyStimulus(isMac, isWrite, addr, data, strb);
    expErr = useTable ? tErr : mErr;
    expMac = useTable ? tMac : refMacRd;
    expCpu = useTable ? tCpu : refCpuRd;
    checkOutput("latency", 32'(pulseK), 32'd2);
    checkOutput("pulse kind", 32'(kind), !isMac ? 32'h1 : (expErr ? 32'h2 : 32'h4));
    checkOutput("mem_en cycles", 32'(enCount), expErr ? 32'd0 : 32'd1);
    checkOutput("busy cycles", 32'(busyCount), 32'd2);
    if (!expErr) begin
      checkOutput("mem_addr", 32'(addrSeen), 32'(mIdx));
      checkOutput("mem_we", 32'(weSeen), mWr ? 32'(strb) : 32'h0);
    end
    checkOutput("mac read data", m_wb_dat_o, expMac);
    checkOutput("cpu read data", rdata, expCpu);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [11:0] ackSeen;
    logic [11:0] rdySeen;
    int          rdyCount;
    logic        rIsMac, rIsWrite;
    logic [31:0] rAddr;
    logic [3:0]  rStrb;

    for (int i = 0; i < 2048; i++) refMem[i] = '0;
    modelReset();

    vecs[0]  = '{1'b1, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0,        32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0020, 32'hFFFFFFFF, 4'hF, 1'b0, 32'hDEADBEEF, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h11223344, 4'h3, 1'b0, 32'hDEADBEEF, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF, 32'hFFFF3344};
    vecs[5]  = '{1'b1, 1'b1, 32'h0000_2000, 32'h12345678, 4'hF, 1'b1, 32'hDEADBEEF, 32'hFFFF3344};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,        4'h0, 1'b0, 32'h0,        32'hFFFF3344};
    vecs[7]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,        4'h0, 1'b0, 32'h0,        32'hDEADBEEF};
    vecs[8]  = '{1'b1, 1'b1, 32'h0000_0010, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0,        32'hDEADBEEF};
    vecs[9]  = '{1'b0, 1'b0, 32'h0000_2010, 32'h0,        4'h0, 1'b0, 32'h0,        32'hCAFEF00D};
    vecs[10] = '{1'b1, 1'b0, 32'hFFFF_0010, 32'h0,        4'h0, 1'b1, 32'h0,        32'hCAFEF00D};
    vecs[11] = '{1'b1, 1'b1, 32'h0000_1FFC, 32'hA5A5A5A5, 4'hC, 1'b0, 32'h0,        32'hCAFEF00D};
    vecs[12] = '{1'b0, 1'b0, 32'h0000_1FFC, 32'h0,        4'h0, 1'b0, 32'h0,        32'hA5A50000};
    vecs[13] = '{1'b1, 1'b0, 32'h0000_1FFC, 32'h0,        4'h0, 1'b0, 32'hA5A50000, 32'hA5A50000};

    repeat (3) @(negedge clk);
    checkOutput("reset mem_en", 32'(mem_en), 32'h0);
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset pulses", 32'({m_wb_ack_o, m_wb_err_o, ready}), 32'h0);
    checkOutput("reset mem_we/addr", 32'({mem_we, mem_addr}), 32'h0);
    checkOutput("reset mem_wdata", mem_wdata, 32'h0);
    checkOutput("reset mac data", m_wb_dat_o, 32'h0);
    checkOutput("reset cpu data", rdata, 32'h0);
    @(posedge clk); #1 rst = 1'b1;

    for (int i = 0; i < 14; i++)
      exercise(vecs[i].isMac, vecs[i].isWrite, vecs[i].addr, vecs[i].data, vecs[i].strb,
               1'b1, vecs[i].expErr, vecs[i].expMac, vecs[i].expCpu);

    // Contention from reset: MAC first, then strict alternation while both hold.
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    modelReset();
    @(posedge clk); #1;
    m_wb_cyc_i = 1'b1; m_wb_stb_i = 1'b1; m_wb_we_i = 1'b0; m_wb_adr_i = 32'h10;
    valid = 1'b1; address = 16'h20; wstrb = 4'h0;
    ackSeen = '0; rdySeen = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      ackSeen[k] = m_wb_ack_o;
      rdySeen[k] = ready;
    end
    @(posedge clk); #1;
    dropRequests();
    @(negedge clk);
    refMacRd = refMem[4];
    refCpuRd = refMem[8];
    checkOutput("contention ack cycles", 32'(ackSeen), 32'h104);
    checkOutput("contention ready cycles", 32'(rdySeen), 32'h820);
    checkOutput("contention mac data", m_wb_dat_o, refMacRd);
    checkOutput("contention cpu data", rdata, refCpuRd);

    // Reset while a CPU write is in ACCESS: the write and its pulse are dropped.
    @(posedge clk); #1;
    valid = 1'b1; address = 16'h40; wdata = 32'h55AA55AA; wstrb = 4'hF;
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort access mem_en", 32'(mem_en), 32'h1);
    checkOutput("abort access busy", 32'(busy), 32'h1);
    #1 rst = 1'b0;
    dropRequests();
    #1;
    checkOutput("abort mem_en low", 32'(mem_en), 32'h0);
    checkOutput("abort busy low", 32'(busy), 32'h0);
    checkOutput("abort mem_we low", 32'(mem_we), 32'h0);
    checkOutput("abort cpu data cleared", rdata, 32'h0);
    checkOutput("abort mac data cleared", m_wb_dat_o, 32'h0);
    rdyCount = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (ready) rdyCount++;
    end
    checkOutput("abort no ready", 32'(rdyCount), 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    modelReset();
    exercise(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 1'b0, '0, '0);

    for (int n = 0; n < 60; n++) begin
      rIsMac   = 1'($urandom_range(0, 1));
      rIsWrite = 1'($urandom_range(0, 1));
      rAddr    = {19'b0, 11'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      rStrb    = 4'($urandom_range(0, 15));
      if (rIsMac && $urandom_range(0, 5) == 0) rAddr[31:13] = 19'($urandom_range(1, 524287));
      if (!rIsMac) rAddr[15:13] = 3'($urandom_range(0, 7));
      if (!rIsMac && rIsWrite && rStrb == 4'h0) rStrb = 4'hF;
      exercise(rIsMac, rIsWrite, rAddr, $urandom, rStrb, 1'b0, 1'b0, '0, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
